// File: rtl/ahbl_to_apb_if.sv
// Bus bundle for the AHB-Lite to APB3 bridge: the AHB-Lite slave port and the APB3 master port.
// slave = the bridge's view, master = the view of whatever surrounds the bridge.
interface ahbl_to_apb_if #(
    parameter int W_HADDR = 32,
    parameter int W_PADDR = 16,
    parameter int W_DATA  = 32
);
    logic               ahbls_hready;
    logic               ahbls_hready_resp;
    logic               ahbls_hresp;
    logic [W_HADDR-1:0] ahbls_haddr;
    logic               ahbls_hwrite;
    logic [1:0]         ahbls_htrans;
    logic [2:0]         ahbls_hsize;
    logic [2:0]         ahbls_hburst;
    logic [3:0]         ahbls_hprot;
    logic               ahbls_hmastlock;
    logic [W_DATA-1:0]  ahbls_hwdata;
    logic [W_DATA-1:0]  ahbls_hrdata;

    logic [W_PADDR-1:0] apbm_paddr;
    logic               apbm_psel;
    logic               apbm_penable;
    logic               apbm_pwrite;
    logic [W_DATA-1:0]  apbm_pwdata;
    logic [W_DATA-1:0]  apbm_prdata;
    logic               apbm_pready;
    logic               apbm_pslverr;

    modport slave (
        input  ahbls_hready,
        output ahbls_hready_resp,
        output ahbls_hresp,
        input  ahbls_haddr,
        input  ahbls_hwrite,
        input  ahbls_htrans,
        input  ahbls_hsize,
        input  ahbls_hburst,
        input  ahbls_hprot,
        input  ahbls_hmastlock,
        input  ahbls_hwdata,
        output ahbls_hrdata,
        output apbm_paddr,
        output apbm_psel,
        output apbm_penable,
        output apbm_pwrite,
        output apbm_pwdata,
        input  apbm_prdata,
        input  apbm_pready,
        input  apbm_pslverr
    );

    modport master (
        output ahbls_hready,
        input  ahbls_hready_resp,
        input  ahbls_hresp,
        output ahbls_haddr,
        output ahbls_hwrite,
        output ahbls_htrans,
        output ahbls_hsize,
        output ahbls_hburst,
        output ahbls_hprot,
        output ahbls_hmastlock,
        output ahbls_hwdata,
        input  ahbls_hrdata,
        input  apbm_paddr,
        input  apbm_psel,
        input  apbm_penable,
        input  apbm_pwrite,
        input  apbm_pwdata,
        output apbm_prdata,
        output apbm_pready,
        output apbm_pslverr
    );
endinterface

// File: rtl/ahbl_to_apb.sv
// AHB-Lite slave that re-issues every transfer as one APB3 access, holding AHB wait states throughout.
// Define APB_BRIDGE_SLVERR_EN to turn PSLVERR into a two-cycle AHB ERROR response (ERR1/ERR2).
module ahbl_to_apb #(
    parameter int W_HADDR = 32,
    parameter int W_PADDR = 16,
    parameter int W_DATA  = 32
) (
    input logic          clk,
    input logic          rst,
    ahbl_to_apb_if.slave bus_io
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3
`ifdef APB_BRIDGE_SLVERR_EN
        ,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
`endif
    } state_e;

    state_e state_q, state_d;

    logic [W_PADDR-1:0] paddr_q, paddr_d;
    logic               pwrite_q, pwrite_d;
    logic [W_DATA-1:0]  hrdata_q, hrdata_d;

    logic ready_resp, hresp, psel, penable;
    logic in_err2, can_accept, accept, access_done;

`ifdef APB_BRIDGE_SLVERR_EN
    assign in_err2 = (state_q == ST_ERR2);
`else
    assign in_err2 = 1'b0;
`endif

    // A new address phase is only taken in cycles where this slave finishes (or has no) data phase.
    assign can_accept  = (state_q == ST_IDLE) || (state_q == ST_RESP) || in_err2;
    assign accept      = can_accept && bus_io.ahbls_hready && bus_io.ahbls_htrans[1];
    assign access_done = (state_q == ST_ACCESS) && bus_io.apbm_pready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus_io.apbm_pready) begin
`ifdef APB_BRIDGE_SLVERR_EN
                    state_d = bus_io.apbm_pslverr ? ST_ERR1 : ST_RESP;
`else
                    state_d = ST_RESP;
`endif
                end
            end
            ST_RESP: begin
                state_d = accept ? ST_SETUP : ST_IDLE;
            end
`ifdef APB_BRIDGE_SLVERR_EN
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                state_d = accept ? ST_SETUP : ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ready_resp = 1'b1;
        hresp      = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        unique case (state_q)
            ST_SETUP: begin
                psel       = 1'b1;
                ready_resp = 1'b0;
            end
            ST_ACCESS: begin
                psel       = 1'b1;
                penable    = 1'b1;
                ready_resp = 1'b0;
            end
`ifdef APB_BRIDGE_SLVERR_EN
            ST_ERR1: begin
                ready_resp = 1'b0;
                hresp      = 1'b1;
            end
            ST_ERR2: begin
                hresp      = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    // Address/direction frozen from accept through the last ACCESS cycle; read data only on reads.
    always_comb begin
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        hrdata_d = hrdata_q;
        if (accept) begin
            paddr_d  = bus_io.ahbls_haddr[W_PADDR-1:0];
            pwrite_d = bus_io.ahbls_hwrite;
        end
        if (access_done && !pwrite_q) begin
            hrdata_d = bus_io.apbm_prdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            hrdata_q <= '0;
        end else begin
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign bus_io.ahbls_hready_resp = ready_resp;
    assign bus_io.ahbls_hresp       = hresp;
    assign bus_io.ahbls_hrdata      = hrdata_q;
    assign bus_io.apbm_paddr        = paddr_q;
    assign bus_io.apbm_psel         = psel;
    assign bus_io.apbm_penable      = penable;
    assign bus_io.apbm_pwrite       = pwrite_q;
    // The AHB master holds HWDATA for the whole data phase, so no local copy is needed.
    assign bus_io.apbm_pwdata       = bus_io.ahbls_hwdata;

    logic unused_ok;
    assign unused_ok = ^{bus_io.ahbls_haddr[W_HADDR-1:W_PADDR],
                         bus_io.ahbls_htrans[0],
                         bus_io.ahbls_hsize,
                         bus_io.ahbls_hburst,
                         bus_io.ahbls_hprot,
                         bus_io.ahbls_hmastlock
`ifndef APB_BRIDGE_SLVERR_EN
                         , bus_io.apbm_pslverr
`endif
                        };

endmodule

// File: tb/tb_ahbl_to_apb.sv
// Scoreboard bench for ahbl_to_apb: AHB driver, APB slave model, AHB and APB monitors.
module tb_ahbl_to_apb;
    localparam int W_HADDR = 32;
    localparam int W_PADDR = 16;
    localparam int W_DATA  = 32;
`ifdef APB_BRIDGE_SLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ahbl_to_apb_if #(.W_HADDR(W_HADDR), .W_PADDR(W_PADDR), .W_DATA(W_DATA)) bus ();

    ahbl_to_apb #(.W_HADDR(W_HADDR), .W_PADDR(W_PADDR), .W_DATA(W_DATA)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    // Single-slave system: system HREADY is this slave's HREADYOUT unless forced low.
    assign bus.ahbls_hready = bus.ahbls_hready_resp & ~stall;

    typedef struct {
        logic [W_PADDR-1:0] addr;
        logic               wr;
        logic [W_DATA-1:0]  wdata;
        int                 wait_n;
        logic               err;
        logic [W_DATA-1:0]  rdata;
    } apb_t;

    typedef struct {
        logic              resp;
        logic [W_DATA-1:0] rdata;
        int                lat;
    } rsp_t;

    apb_t              apb_q[$];
    rsp_t              rsp_q[$];
    apb_t              cur;
    int                acc_cnt = 0;
    logic [W_DATA-1:0] last_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // APB slave model: parameters of the current access are taken from the scoreboard head at SETUP.
    assign bus.apbm_pready  = bus.apbm_psel & bus.apbm_penable & (acc_cnt >= cur.wait_n);
    assign bus.apbm_pslverr = bus.apbm_pready & cur.err;
    assign bus.apbm_prdata  = bus.apbm_pready ? cur.rdata : ~cur.rdata;

    always @(posedge clk) begin
        if (bus.apbm_psel && !bus.apbm_penable && apb_q.size() > 0) cur <= apb_q[0];
        if (bus.apbm_psel && bus.apbm_penable && !bus.apbm_pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(negedge clk) begin
        if (!rst && bus.apbm_psel && bus.apbm_penable && bus.apbm_pready) begin
            if (apb_q.size() == 0) chk("apb_unexpected", 64'd1, 64'd0);
            else begin
                apb_t e;
                e = apb_q.pop_front();
                chk("paddr", bus.apbm_paddr, e.addr);
                chk("pwrite", bus.apbm_pwrite, e.wr);
                if (e.wr) chk("pwdata", bus.apbm_pwdata, e.wdata);
            end
        end
    end

    // AHB monitor: tracks the data phase and its length in cycles.
    logic dphase;
    int   dcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dphase <= 1'b0;
            dcnt   <= 0;
        end else if (bus.ahbls_hready) begin
            dphase <= bus.ahbls_htrans[1];
            dcnt   <= 1;
        end else begin
            dcnt   <= dcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst && dphase && bus.ahbls_hready_resp) begin
            if (rsp_q.size() == 0) chk("ahb_unexpected", 64'd1, 64'd0);
            else begin
                rsp_t r;
                r = rsp_q.pop_front();
                chk("hresp", bus.ahbls_hresp, r.resp);
                chk("hrdata", bus.ahbls_hrdata, r.rdata);
                chk("latency", dcnt, r.lat);
                chk("psel_in_resp", bus.apbm_psel, 1'b0);
            end
        end
    end

    task automatic issue(input logic [W_HADDR-1:0] addr, input logic wr, input logic [W_DATA-1:0] wdata,
                         input int wait_n, input logic err, input logic [W_DATA-1:0] rdat);
        apb_t a;
        rsp_t r;
        bit   ok;
        a.addr   = addr[W_PADDR-1:0];
        a.wr     = wr;
        a.wdata  = wdata;
        a.wait_n = wait_n;
        a.err    = err;
        a.rdata  = rdat;
        if (!wr) last_rd = rdat;
        r.resp   = err & ERR_EN;
        r.rdata  = last_rd;
        r.lat    = 3 + wait_n + ((err && ERR_EN) ? 1 : 0);
        apb_q.push_back(a);
        rsp_q.push_back(r);
        bus.ahbls_haddr  = addr;
        bus.ahbls_hwrite = wr;
        bus.ahbls_htrans = 2'b10;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.ahbls_hready;
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.ahbls_htrans = 2'b00;
        bus.ahbls_hwdata = wdata;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((rsp_q.size() != 0 || apb_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) chk("done_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ahbls_haddr     = '0;
        bus.ahbls_hwrite    = 1'b0;
        bus.ahbls_htrans    = 2'b00;
        bus.ahbls_hsize     = 3'b010;
        bus.ahbls_hburst    = 3'b000;
        bus.ahbls_hprot     = 4'b0011;
        bus.ahbls_hmastlock = 1'b0;
        bus.ahbls_hwdata    = '0;
        last_rd             = '0;
        rst                 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.ahbls_hready_resp, 1'b1);
        chk("rst_hresp", bus.ahbls_hresp, 1'b0);
        chk("rst_psel", bus.apbm_psel, 1'b0);
        chk("rst_penable", bus.apbm_penable, 1'b0);
        chk("rst_pwrite", bus.apbm_pwrite, 1'b0);
        chk("rst_paddr", bus.apbm_paddr, 16'h0000);
        chk("rst_hrdata", bus.ahbls_hrdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single zero-wait write
        issue(32'h4000_1234, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'hFFFF_0000);
        @(negedge clk);
        chk("w_c1_psel", bus.apbm_psel, 1'b1);
        chk("w_c1_penable", bus.apbm_penable, 1'b0);
        chk("w_c1_ready", bus.ahbls_hready_resp, 1'b0);
        chk("w_c1_paddr", bus.apbm_paddr, 16'h1234);
        chk("w_c1_pwrite", bus.apbm_pwrite, 1'b1);
        @(negedge clk);
        chk("w_c2_psel", bus.apbm_psel, 1'b1);
        chk("w_c2_penable", bus.apbm_penable, 1'b1);
        chk("w_c2_ready", bus.ahbls_hready_resp, 1'b0);
        wait_done();

        // Read with three wait states
        issue(32'h4000_0010, 1'b0, 32'h0, 3, 1'b0, 32'hCAFE_F00D);
        wait_done();
        chk("r_hold", bus.ahbls_hrdata, 32'hCAFE_F00D);

        // Back-to-back write then read
        issue(32'h4000_0100, 1'b1, 32'h1111_2222, 1, 1'b0, 32'hAAAA_0000);
        issue(32'h4000_0104, 1'b0, 32'h0, 0, 1'b0, 32'h5A5A_A5A5);
        @(negedge clk);
        chk("b2b_setup_psel", bus.apbm_psel, 1'b1);
        chk("b2b_setup_penable", bus.apbm_penable, 1'b0);
        chk("b2b_setup_pwrite", bus.apbm_pwrite, 1'b0);
        chk("b2b_setup_paddr", bus.apbm_paddr, 16'h0104);
        wait_done();

        // Slave error on a write, then on a read
        issue(32'h4000_0200, 1'b1, 32'h0BAD_F00D, 0, 1'b1, 32'h0000_FFFF);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("err_c3_ready", bus.ahbls_hready_resp, !ERR_EN);
        chk("err_c3_hresp", bus.ahbls_hresp, ERR_EN);
        chk("err_c3_psel", bus.apbm_psel, 1'b0);
        wait_done();
        issue(32'h4000_0204, 1'b0, 32'h0, 2, 1'b1, 32'h1357_9BDF);
        wait_done();

        // IDLE / BUSY transfers
        for (int i = 0; i < 6; i++) begin
            bus.ahbls_htrans = (i % 2 == 1) ? 2'b01 : 2'b00;
            bus.ahbls_haddr  = 32'h4000_0000 + 32'(i * 4);
            @(negedge clk);
            chk("idle_psel", bus.apbm_psel, 1'b0);
            chk("idle_ready", bus.ahbls_hready_resp, 1'b1);
            chk("idle_hresp", bus.ahbls_hresp, 1'b0);
            @(posedge clk);
            #1;
        end

        // NONSEQ presented while system HREADY is low must be ignored
        stall            = 1'b1;
        bus.ahbls_htrans = 2'b10;
        bus.ahbls_haddr  = 32'h4000_0300;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_psel", bus.apbm_psel, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.ahbls_htrans = 2'b00;
        stall            = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_after_psel", bus.apbm_psel, 1'b0);
        end
        @(posedge clk);
        #1;

        // Reset in the middle of a stalled ACCESS
        issue(32'h4000_0400, 1'b0, 32'h0, 1000, 1'b0, 32'h7777_8888);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("mid_penable", bus.apbm_penable, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_psel", bus.apbm_psel, 1'b0);
        chk("mid_rst_penable", bus.apbm_penable, 1'b0);
        chk("mid_rst_ready", bus.ahbls_hready_resp, 1'b1);
        chk("mid_rst_hresp", bus.ahbls_hresp, 1'b0);
        chk("mid_rst_hrdata", bus.ahbls_hrdata, 32'h0);
        chk("mid_rst_paddr", bus.apbm_paddr, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apb_q.delete();
        rsp_q.delete();
        last_rd = '0;

        // Clean transfers after reset; the write must leave hrdata untouched
        issue(32'h4000_0500, 1'b0, 32'h0, 0, 1'b0, 32'h2468_1357);
        wait_done();
        issue(32'h4000_0504, 1'b1, 32'hFEED_C0DE, 2, 1'b0, 32'h9999_9999);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
